spiker_word_packer: RTL

Upstream stage of the spiker reader path. Accepts spike data one register word at a time over a valid/ready handshake, assembles `N_SPIKES` bits into a packed frame, and presents the frame with valid/ready to the reader stage. Sits between the register-file spike words and `spiker_reader`, replacing the flat combinational concatenation with a flow-controlled loader.

---
 rtl/spiker_word_packer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spiker_word_packer.sv
// Flow-controlled loader that assembles N_SPIKES spike bits from WIDTH-bit words into one frame.
// Optional per-frame popcount on spike_count_o is built only when SPIKER_PACKER_POPCOUNT_EN is defined.
module spiker_word_packer #(
    parameter int WIDTH    = 32,
    parameter int N_SPIKES = 784,
    localparam int N_WORDS = (N_SPIKES + WIDTH - 1) / WIDTH,
    localparam int IW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
    localparam int CW      = $clog2(N_SPIKES + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                word_valid_i,
    input  logic [WIDTH-1:0]    word_i,
    output logic                word_ready_o,
    output logic                frame_valid_o,
    input  logic                frame_ready_i,
    output logic [N_SPIKES-1:0] spikes_o,
    output logic [IW-1:0]       word_idx_o,
    output logic [CW-1:0]       spike_count_o
);

    // Handshakes: a word moves when word_valid_i & word_ready_o at a rising edge (and no clear_i);
    // a frame moves when frame_valid_o & frame_ready_i. Ready/valid outputs decode registered state only.
    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       word_idx_q;
    logic [N_SPIKES-1:0] spikes_q;
    logic                accept;
    logic                last_word;

    assign word_ready_o  = (state_q == S_FILL);
    assign frame_valid_o = (state_q == S_FULL);
    assign word_idx_o    = word_idx_q;
    assign spikes_o      = spikes_q;

    assign last_word = (word_idx_q == IW'(N_WORDS - 1));
    assign accept    = word_valid_i & word_ready_o & ~clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_FILL;
        end else begin
            case (state_q)
                S_FILL:  if (accept && last_word) state_d = S_FULL;
                S_FULL:  if (frame_ready_i) state_d = S_FILL;
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_idx_q <= '0;
        end else if (clear_i) begin
            word_idx_q <= '0;
        end else if (accept) begin
            word_idx_q <= last_word ? '0 : word_idx_q + IW'(1);
        end
    end

    // Bit-wise write so the last word's bits beyond N_SPIKES simply have no destination.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spikes_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_SPIKES; i++) begin
                if (word_idx_q == IW'(i / WIDTH)) begin
                    spikes_q[i] <= word_i[i % WIDTH];
                end
            end
        end
    end

`ifdef SPIKER_PACKER_POPCOUNT_EN
    localparam int              LAST_BITS = N_SPIKES - (N_WORDS - 1) * WIDTH;
    localparam logic [WIDTH-1:0] LAST_MASK = {WIDTH{1'b1}} >> (WIDTH - LAST_BITS);

    logic [WIDTH-1:0] masked_word;
    logic [CW-1:0]    word_pop;
    logic [CW-1:0]    count_q;

    always_comb begin
        masked_word = last_word ? (word_i & LAST_MASK) : word_i;
        word_pop    = '0;
        for (int j = 0; j < WIDTH; j++) begin
            word_pop = word_pop + CW'(masked_word[j]);
        end
    end

    // Index 0 marks the first accept of a frame, so the running count restarts there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= ((word_idx_q == '0) ? '0 : count_q) + word_pop;
        end
    end

    assign spike_count_o = count_q;
`else
    assign spike_count_o = '0;
`endif

endmodule
